// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input and converts
// them to a DUTY_W-bit duty value with a bit-serial restoring divider.
module pwm_capture #(
   parameter int CTR_LEN = 25,
   parameter int DUTY_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pwm_in,
   output logic [DUTY_W-1:0]  duty,
   output logic [CTR_LEN-1:0] period_out,
   output logic [CTR_LEN-1:0] high_out,
   output logic               valid,
   output logic               stuck,
   output logic               overrun
);
   localparam int                 BCW   = $clog2(DUTY_W + 1);
   localparam logic [CTR_LEN-1:0] CMAX  = {CTR_LEN{1'b1}};
   localparam logic [BCW-1:0]     BLAST = BCW'(DUTY_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DIVIDE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_s1;
   logic                r_s2;
   logic                r_s3;
   logic                w_rise;
   logic [CTR_LEN-1:0]  r_pcnt;
   logic [CTR_LEN-1:0]  r_hcnt;
   logic [CTR_LEN-1:0]  r_pq;
   logic [CTR_LEN-1:0]  r_hq;
   logic [CTR_LEN-1:0]  r_rem;
   logic [CTR_LEN:0]    w_rem_sh;
   logic [CTR_LEN-1:0]  w_rem_nxt;
   logic [DUTY_W-2:0]   r_quo;
   logic [DUTY_W-1:0]   w_quo_nxt;
   logic [BCW-1:0]      r_bcnt;
   logic                w_ge;
   logic                w_div_last;
   logic                w_tmo;
   logic                w_capture;

   assign w_rise     = r_s2 & ~r_s3;
   assign w_capture  = (r_state == ST_MEASURE) && w_rise;
   assign w_div_last = (r_state == ST_DIVIDE) && (r_bcnt == BLAST);
   // A rise in the same cycle always beats the timeout; DIVIDE defers it until the divider is done.
   assign w_tmo      = (r_pcnt == CMAX) && !w_rise && (r_state != ST_DIVIDE) && !stuck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= pwm_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
         r_hcnt <= '0;
      end else if (w_rise) begin
         r_pcnt <= {{(CTR_LEN-1){1'b0}}, 1'b1};
         r_hcnt <= {{(CTR_LEN-1){1'b0}}, 1'b1};
      end else begin
         if (r_pcnt != CMAX) begin
            r_pcnt <= r_pcnt + {{(CTR_LEN-1){1'b0}}, 1'b1};
         end
         if (r_hcnt != CMAX) begin
            r_hcnt <= r_hcnt + {{(CTR_LEN-1){1'b0}}, r_s2};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) w_state_nxt = ST_MEASURE;
            else        w_state_nxt = ST_IDLE;
         end
         ST_MEASURE: begin
            if (w_rise)      w_state_nxt = ST_DIVIDE;
            else if (w_tmo)  w_state_nxt = ST_IDLE;
            else             w_state_nxt = ST_MEASURE;
         end
         ST_DIVIDE: begin
            if (w_div_last) w_state_nxt = ST_MEASURE;
            else            w_state_nxt = ST_DIVIDE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The dividend's low DUTY_W bits are zero, so each step shifts a zero into the remainder.
   always_comb begin
      w_rem_sh = {r_rem, 1'b0};
      w_ge     = (w_rem_sh >= {1'b0, r_pq});
      if (w_ge) begin
         w_rem_nxt = CTR_LEN'(w_rem_sh - {1'b0, r_pq});
      end else begin
         w_rem_nxt = CTR_LEN'(w_rem_sh);
      end
      w_quo_nxt = {r_quo, w_ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pq   <= '0;
         r_hq   <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_bcnt <= '0;
      end else if (w_capture) begin
         r_pq   <= r_pcnt;
         r_hq   <= r_hcnt;
         r_rem  <= r_hcnt;
         r_quo  <= '0;
         r_bcnt <= '0;
      end else if (r_state == ST_DIVIDE) begin
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt[DUTY_W-2:0];
         r_bcnt <= r_bcnt + BCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty       <= '0;
         period_out <= '0;
         high_out   <= '0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= w_rise && (r_state == ST_DIVIDE);
         if (w_div_last) begin
            duty       <= w_quo_nxt;
            period_out <= r_pq;
            high_out   <= r_hq;
            valid      <= 1'b1;
         end else if (w_tmo) begin
            duty       <= {DUTY_W{r_s2}};
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b1;
         end else begin
            valid      <= 1'b0;
         end
         if (w_rise) begin
            stuck <= 1'b0;
         end else if (w_tmo) begin
            stuck <= 1'b1;
         end
      end
   end
endmodule
